// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the 16-bit CPU: latches an instruction, then steps T0-T3 driving datapath controls.
// Define CPU_CTRL_LOGIC_EN to make the and (0100) / or (0101) opcodes legal.
module cpu_control_unit #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [DW-1:0] din,
  output logic          ir_in,
  output logic [3:0]    r_in_sel,
  output logic          r_in_en,
  output logic [3:0]    r_out_sel,
  output logic          r_out_en,
  output logic          din_out,
  output logic          g_out,
  output logic          a_in,
  output logic          g_in,
  output logic [1:0]    alu_op,
  output logic          done,
  output logic          illegal
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] ir;
  logic [3:0]    opcode, rx, ry;
  logic [3:0]    ir_lsb_unused;
  logic          is_mv, is_mvi, is_alu, legal;
  logic [1:0]    alu_code;

  assign opcode        = ir[DW-1 -: 4];
  assign rx            = ir[DW-5 -: 4];
  assign ry            = ir[DW-9 -: 4];
  assign ir_lsb_unused = ir[DW-13 -: 4];

  assign is_mv  = (opcode == 4'b0000);
  assign is_mvi = (opcode == 4'b0001);

  // The ALU code is always derived from the opcode so it is stable outside g_in.
`ifdef CPU_CTRL_LOGIC_EN
  assign is_alu = (opcode == 4'b0010) || (opcode == 4'b0011) ||
                  (opcode == 4'b0100) || (opcode == 4'b0101);
  always_comb begin
    alu_code = 2'b00;
    case (opcode)
      4'b0011: alu_code = 2'b01;
      4'b0100: alu_code = 2'b10;
      4'b0101: alu_code = 2'b11;
      default: alu_code = 2'b00;
    endcase
  end
`else
  assign is_alu   = (opcode == 4'b0010) || (opcode == 4'b0011);
  assign alu_code = {1'b0, opcode == 4'b0011};
`endif

  // Only R0-R7 exist; mvi has no Ry operand so its Ry field is not checked.
  assign legal = (is_mv  && !rx[3] && !ry[3]) ||
                 (is_mvi && !rx[3]) ||
                 (is_alu && !rx[3] && !ry[3]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && run)
        ir <= din;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_in     = 1'b0;
    r_in_sel  = rx;
    r_in_en   = 1'b0;
    r_out_sel = ry;
    r_out_en  = 1'b0;
    din_out   = 1'b0;
    g_out     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    alu_op    = alu_code;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      T0: begin
        ir_in = run;
        if (run)
          state_nxt = T1;
      end
      T1: begin
        if (!legal) begin
          done      = 1'b1;
          illegal   = 1'b1;
          state_nxt = T0;
        end else if (is_mv) begin
          r_out_en  = 1'b1;
          r_in_en   = 1'b1;
          done      = 1'b1;
          state_nxt = T0;
        end else if (is_mvi) begin
          din_out   = 1'b1;
          r_in_en   = 1'b1;
          done      = 1'b1;
          state_nxt = T0;
        end else begin
          r_out_sel = rx;
          r_out_en  = 1'b1;
          a_in      = 1'b1;
          state_nxt = T2;
        end
      end
      T2: begin
        r_out_en  = 1'b1;
        g_in      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        g_out     = 1'b1;
        r_in_en   = 1'b1;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed and random instructions against an instruction-level model.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] din;
  logic        ir_in, r_in_en, r_out_en, din_out, g_out, a_in, g_in, done, illegal;
  logic [3:0]  r_in_sel, r_out_sel;
  logic [1:0]  alu_op;

  int          checkCount = 0;
  int          failCount  = 0;
  bit          logicEn;
  logic [15:0] lastIr;

  cpu_control_unit #(.DW(16)) dut (
    .clk(clk), .reset(reset), .run(run), .din(din),
    .ir_in(ir_in), .r_in_sel(r_in_sel), .r_in_en(r_in_en),
    .r_out_sel(r_out_sel), .r_out_en(r_out_en), .din_out(din_out),
    .g_out(g_out), .a_in(a_in), .g_in(g_in), .alu_op(alu_op),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Flag order: ir_in r_in_en r_out_en din_out g_out a_in g_in done illegal
  function automatic void model(input logic [15:0] ins, input int step, input bit logicOn,
                                output logic [8:0] flags, output logic [3:0] outSel,
                                output logic [1:0] op, output int nSteps);
    int opc, rx, ry;
    bit alu, ok;
    opc = int'(ins[15:12]);
    rx  = int'(ins[11:8]);
    ry  = int'(ins[7:4]);
    alu = (opc == 2) || (opc == 3) || (logicOn && (opc == 4 || opc == 5));
    ok  = (opc == 0 && rx < 8 && ry < 8) || (opc == 1 && rx < 8) || (alu && rx < 8 && ry < 8);
    op  = (opc == 3) ? 2'd1 : (logicOn && opc == 4) ? 2'd2 : (logicOn && opc == 5) ? 2'd3 : 2'd0;
    nSteps = (ok && alu) ? 3 : 1;
    outSel = ins[7:4];
    flags  = '0;
    if (!ok)
      flags = 9'b000000011;
    else if (opc == 0)
      flags = 9'b011000010;
    else if (opc == 1)
      flags = 9'b010100010;
    else if (step == 1) begin
      flags  = 9'b001001000;
      outSel = ins[11:8];
    end else if (step == 2)
      flags = 9'b001000100;
    else
      flags = 9'b010010010;
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] ef, input logic [3:0] eIn,
                             input logic [3:0] eOut, input logic [1:0] eOp, input bit forceAll);
    logic [8:0] af;
    af = {ir_in, r_in_en, r_out_en, din_out, g_out, a_in, g_in, done, illegal};
    checkCount++;
    assert (af === ef) else begin
      failCount++;
      $error("[TB] FAIL %s flags got %b want %b", tag, af, ef);
    end
    checkCount++;
    assert (r_in_sel === eIn) else begin
      failCount++;
      $error("[TB] FAIL %s r_in_sel got %0d want %0d", tag, r_in_sel, eIn);
    end
    if (forceAll || ef[6]) begin
      checkCount++;
      assert (r_out_sel === eOut) else begin
        failCount++;
        $error("[TB] FAIL %s r_out_sel got %0d want %0d", tag, r_out_sel, eOut);
      end
    end
    if (forceAll || ef[2]) begin
      checkCount++;
      assert (alu_op === eOp) else begin
        failCount++;
        $error("[TB] FAIL %s alu_op got %b want %b", tag, alu_op, eOp);
      end
    end
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    run = 1'b0;
    din = 16'($urandom);
    #1 checkOutput(tag, 9'b0, lastIr[11:8], 4'd0, 2'd0, 1'b0);
  endtask

  // Accepts one instruction and checks every step; run is randomised after accept and must be ignored.
  task automatic applyStimulus(input string tag, input logic [15:0] ins, input logic [15:0] imm);
    logic [8:0] ef;
    logic [3:0] eOut;
    logic [1:0] eOp;
    int         n;
    @(negedge clk);
    run = 1'b1;
    din = ins;
    #1 checkOutput({tag, ".accept"}, 9'b100000000, lastIr[11:8], 4'd0, 2'd0, 1'b0);
    model(ins, 1, logicEn, ef, eOut, eOp, n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      din = (k == 1) ? imm : 16'($urandom);
      model(ins, k, logicEn, ef, eOut, eOp, n);
      #1 checkOutput($sformatf("%s.T%0d", tag, k), ef, ins[11:8], eOut, eOp, 1'b0);
    end
    lastIr = ins;
  endtask

  initial begin
`ifdef CPU_CTRL_LOGIC_EN
    logicEn = 1'b1;
`else
    logicEn = 1'b0;
`endif
    lastIr = 16'h0000;
    reset  = 1'b1;
    run    = 1'b0;
    din    = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1 checkOutput("reset", 9'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    reset = 1'b0;
    idleCycle("idle0");

    applyStimulus("mvi", 16'h1300, 16'hBEEF);
    idleCycle("mviAfter");
    applyStimulus("add", 16'h2250, 16'h0000);
    applyStimulus("illegalReg", 16'h0A10, 16'h0000);
    applyStimulus("op4", 16'h4130, 16'h0000);
    applyStimulus("b2bMv", 16'h0120, 16'h0000);
    applyStimulus("b2bSub", 16'h3460, 16'h0000);
    applyStimulus("illegalOp", 16'h7120, 16'h0000);
    applyStimulus("mviHighRy", 16'h15F0, 16'h1234);
    applyStimulus("addBadRy", 16'h2290, 16'h0000);

    // Asynchronous reset in the middle of T2 of an add.
    @(negedge clk);
    run = 1'b1;
    din = 16'h2250;
    #1 checkOutput("rst.accept", 9'b100000000, lastIr[11:8], 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    run = 1'b0;
    #1 checkOutput("rst.T1", 9'b001001000, 4'd2, 4'd2, 2'd0, 1'b0);
    @(negedge clk);
    #1 checkOutput("rst.T2", 9'b001000100, 4'd2, 4'd5, 2'd0, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("rst.async", 9'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    @(negedge clk);
    reset  = 1'b0;
    lastIr = 16'h0000;
    #1 checkOutput("rst.after", 9'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    idleCycle("rst.noDone");

    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom)};
      applyStimulus($sformatf("rand%0d", i), ins, 16'($urandom));
      if ($urandom_range(0, 3) == 0)
        idleCycle($sformatf("randIdle%0d", i));
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
